uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core_if.sv | 26 ++
 rtl/uart_rx_core.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Control and status bundle for uart_rx_core.
// slave is the receiver side, master is whoever drives the line and reads the status.
interface uart_rx_core_if;
    logic       uart_en;
    logic       uart_div_sel;
    logic       uart_prty_en;
    logic       os_tick;
    logic       rxpnd_clr;
    logic       uart_rx;
    logic [7:0] rxbuf;
    logic       rx_9bit;
    logic       uart_rxpnd;
    logic       rx_ferr;
    logic       rx_ovr;
    logic       rx_busy;

    modport master (
        output uart_en, uart_div_sel, uart_prty_en, os_tick, rxpnd_clr, uart_rx,
        input  rxbuf, rx_9bit, uart_rxpnd, rx_ferr, rx_ovr, rx_busy
    );

    modport slave (
        input  uart_en, uart_div_sel, uart_prty_en, os_tick, rxpnd_clr, uart_rx,
        output rxbuf, rx_9bit, uart_rxpnd, rx_ferr, rx_ovr, rx_busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: 8 data bits LSB first, optional 9th bit, one stop bit.
// Status flags are sticky until rxpnd_clr; a STOP-sample set wins over a coincident clear.
module uart_rx_core #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           uart_clk,
    input  logic           sys_rstn,
    uart_rx_core_if.slave  bus
);
    localparam int unsigned TCNT_W = 2;
    localparam int unsigned BCNT_W = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        NINTH = 3'd3,
        STOP  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_q;
    state_t                 r_state;
    logic [TCNT_W-1:0]      r_tcnt;
    logic [BCNT_W-1:0]      r_bcnt;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_ninth;
    logic [DATA_W-1:0]      r_rxbuf;
    logic                   r_rx_9bit;
    logic                   r_rxpnd;
    logic                   r_ferr;
    logic                   r_ovr;
    logic                   r_busy;

    state_t                 w_state_nxt;
    logic [TCNT_W-1:0]      w_tcnt_nxt;
    logic [BCNT_W-1:0]      w_bcnt_nxt;
    logic [DATA_W-1:0]      w_shift_nxt;
    logic                   w_ninth_nxt;
    logic [DATA_W-1:0]      w_rxbuf_nxt;
    logic                   w_rx_9bit_nxt;
    logic                   w_rxpnd_nxt;
    logic                   w_ferr_nxt;
    logic                   w_ovr_nxt;
    logic                   w_busy_nxt;

    logic                   w_rx_s;
    logic [TCNT_W-1:0]      w_tcnt_last;
    logic                   w_sample;
    logic                   w_bit_end;

    // Line synchroniser plus one extra flop for falling-edge detection
    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_sync <= '1;
            r_rx_q <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.uart_rx};
            r_rx_q <= w_rx_s;
        end
    end

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_tcnt_last = bus.uart_div_sel ? TCNT_W'(2) : TCNT_W'(3);
    assign w_sample    = bus.os_tick && (r_tcnt == TCNT_W'(1));
    assign w_bit_end   = bus.os_tick && (r_tcnt == w_tcnt_last);

    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state   <= IDLE;
            r_tcnt    <= '0;
            r_bcnt    <= '0;
            r_shift   <= '0;
            r_ninth   <= 1'b0;
            r_rxbuf   <= '0;
            r_rx_9bit <= 1'b0;
            r_rxpnd   <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ninth   <= w_ninth_nxt;
            r_rxbuf   <= w_rxbuf_nxt;
            r_rx_9bit <= w_rx_9bit_nxt;
            r_rxpnd   <= w_rxpnd_nxt;
            r_ferr    <= w_ferr_nxt;
            r_ovr     <= w_ovr_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next state and registered-output values; the clear is applied first so a STOP set overrides it
    always_comb begin
        w_state_nxt   = r_state;
        w_tcnt_nxt    = r_tcnt;
        w_bcnt_nxt    = r_bcnt;
        w_shift_nxt   = r_shift;
        w_ninth_nxt   = r_ninth;
        w_rxbuf_nxt   = r_rxbuf;
        w_rx_9bit_nxt = r_rx_9bit;
        w_rxpnd_nxt   = r_rxpnd & ~bus.rxpnd_clr;
        w_ferr_nxt    = r_ferr  & ~bus.rxpnd_clr;
        w_ovr_nxt     = r_ovr   & ~bus.rxpnd_clr;

        if (!bus.uart_en) begin
            w_state_nxt = IDLE;
            w_tcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
        end else begin
            if ((r_state != IDLE) && bus.os_tick) begin
                w_tcnt_nxt = w_bit_end ? '0 : r_tcnt + TCNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (r_rx_q && !w_rx_s) begin
                        w_state_nxt = START;
                        w_tcnt_nxt  = '0;
                        w_bcnt_nxt  = '0;
                        w_ninth_nxt = 1'b0;
                    end
                end
                START: begin
                    if (w_sample && w_rx_s) begin
                        w_state_nxt = IDLE;
                        w_tcnt_nxt  = '0;
                    end else if (w_bit_end) begin
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        w_shift_nxt = {w_rx_s, r_shift[DATA_W-1:1]};
                    end
                    if (w_bit_end) begin
                        w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                        if (r_bcnt == BCNT_W'(7)) begin
                            w_state_nxt = bus.uart_prty_en ? NINTH : STOP;
                        end
                    end
                end
                NINTH: begin
                    if (w_sample) begin
                        w_ninth_nxt = w_rx_s;
                    end
                    if (w_bit_end) begin
                        w_state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        w_rxbuf_nxt   = r_shift;
                        w_rx_9bit_nxt = bus.uart_prty_en & r_ninth;
                        w_rxpnd_nxt   = 1'b1;
                        if (!w_rx_s) begin
                            w_ferr_nxt = 1'b1;
                        end
                        if (r_rxpnd) begin
                            w_ovr_nxt = 1'b1;
                        end
                        w_state_nxt = IDLE;
                        w_tcnt_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_tcnt_nxt  = '0;
                    w_bcnt_nxt  = '0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign bus.rxbuf      = r_rxbuf;
    assign bus.rx_9bit    = r_rx_9bit;
    assign bus.uart_rxpnd = r_rxpnd;
    assign bus.rx_ferr    = r_ferr;
    assign bus.rx_ovr     = r_ovr;
    assign bus.rx_busy    = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frames are driven tick-aligned, expected results
// go through a scoreboard queue and are popped once each frame has been received.
module tb_uart_rx_core;
    localparam int unsigned S = 2;

    typedef struct packed {
        logic [7:0] d;
        logic       b9;
        logic       pnd;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic uart_clk = 1'b0;
    logic sys_rstn;

    uart_rx_core_if bus ();

    uart_rx_core #(.SYNC_STAGES(S)) dut (
        .uart_clk (uart_clk),
        .sys_rstn (sys_rstn),
        .bus      (bus)
    );

    always #5 uart_clk = ~uart_clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   ph     = 0;
    exp_t sb_q[$];

    logic [7:0] m_rxbuf;
    logic       m_r9, m_pnd, m_ferr, m_ovr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock; inputs change 1 time unit after the rising edge, os_tick every 4th cycle
    task automatic step();
        @(posedge uart_clk);
        #1;
        ph = (ph + 1) % 4;
        bus.os_tick = (ph == 0);
    endtask

    // Leaves us one cycle before the phase where a falling line puts the first counted tick S+1 cycles later
    task automatic align();
        int p0;
        p0 = (7 - int'(S)) % 4;
        do step(); while (ph != (p0 + 3) % 4);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_rxbuf"}, 32'(bus.rxbuf), 32'(m_rxbuf));
        chk({tag, "_r9"},    32'(bus.rx_9bit), 32'(m_r9));
        chk({tag, "_pnd"},   32'(bus.uart_rxpnd), 32'(m_pnd));
        chk({tag, "_ferr"},  32'(bus.rx_ferr), 32'(m_ferr));
        chk({tag, "_ovr"},   32'(bus.rx_ovr), 32'(m_ovr));
        chk({tag, "_busy"},  32'(bus.rx_busy), 32'd0);
    endtask

    task automatic clear_flags();
        step();
        bus.rxpnd_clr = 1'b1;
        step();
        bus.rxpnd_clr = 1'b0;
        m_pnd = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        chk_flags("clr");
    endtask

    task automatic send_frame(input logic [7:0] d, input logic b9, input logic stop,
                              input logic div, input logic prty, input logic clr_at_stop,
                              input int abort_bit, input string tag);
        int         n, bitlen, nb, js, samp;
        logic [10:0] bits;
        logic       aborted;
        logic       base_ferr, base_ovr;
        exp_t       e;
        n      = div ? 3 : 4;
        bitlen = 4 * n;
        nb     = prty ? 11 : 10;
        js     = prty ? 10 : 9;
        samp   = int'(S) + 5 + bitlen * js;
        bits   = 11'h7FF;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (prty) begin bits[9] = b9; bits[10] = stop; end
        else      begin bits[9] = stop; end
        aborted = 1'b0;
        bus.uart_div_sel = div;
        bus.uart_prty_en = prty;

        if (abort_bit < 0) begin
            base_ferr = clr_at_stop ? 1'b0 : m_ferr;
            base_ovr  = clr_at_stop ? 1'b0 : m_ovr;
            m_ovr   = base_ovr | m_pnd;
            m_ferr  = base_ferr | ~stop;
            m_pnd   = 1'b1;
            m_rxbuf = d;
            m_r9    = prty & b9;
            sb_q.push_back('{d: d, b9: m_r9, pnd: 1'b1, ferr: m_ferr, ovr: m_ovr});
        end

        align();
        for (int off = 0; off < bitlen * (nb + 2); off++) begin
            step();
            if (abort_bit >= 0 && off == bitlen * abort_bit + 2 * n) begin
                aborted = 1'b1;
                bus.uart_en = 1'b0;
                break;
            end
            bus.uart_rx   = (off < bitlen * nb) ? bits[off / bitlen] : 1'b1;
            bus.rxpnd_clr = clr_at_stop && (off == samp);
            if (abort_bit < 0 && off == samp)
                chk({tag, "_busy_at_stop"}, 32'(bus.rx_busy), 32'd1);
            if (abort_bit < 0 && off == samp + 1) begin
                chk({tag, "_pnd_after_stop"}, 32'(bus.uart_rxpnd), 32'd1);
                chk({tag, "_busy_after_stop"}, 32'(bus.rx_busy), 32'd0);
            end
        end
        bus.rxpnd_clr = 1'b0;

        if (aborted) begin
            repeat (3) step();
            chk({tag, "_busy_disabled"}, 32'(bus.rx_busy), 32'd0);
            bus.uart_rx = 1'b1;
            repeat (bitlen) step();
            bus.uart_en = 1'b1;
            repeat (2 * bitlen) step();
            chk_flags({tag, "_abort"});
        end else if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_rxbuf"}, 32'(bus.rxbuf), 32'(e.d));
            chk({tag, "_r9"},    32'(bus.rx_9bit), 32'(e.b9));
            chk({tag, "_pnd"},   32'(bus.uart_rxpnd), 32'(e.pnd));
            chk({tag, "_ferr"},  32'(bus.rx_ferr), 32'(e.ferr));
            chk({tag, "_ovr"},   32'(bus.rx_ovr), 32'(e.ovr));
            chk({tag, "_busy"},  32'(bus.rx_busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d passed of %0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        sys_rstn = 1'b0;
        bus.uart_rx = 1'b1; bus.uart_en = 1'b1; bus.os_tick = 1'b0; bus.rxpnd_clr = 1'b0;
        bus.uart_div_sel = 1'b0; bus.uart_prty_en = 1'b0;
        m_rxbuf = 8'h00; m_r9 = 1'b0; m_pnd = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (3) step();
        chk_flags("reset");
        sys_rstn = 1'b1;
        repeat (4) step();

        // Short low glitch: start detected, rejected at the start-bit sample
        align();
        step(); bus.uart_rx = 1'b0;
        step(); step();
        step(); bus.uart_rx = 1'b1;
        step();
        chk("glitch_busy_start", 32'(bus.rx_busy), 32'd1);
        repeat (40) step();
        chk_flags("glitch");

        // Line held low across enable: no frame without a fresh falling edge
        bus.uart_en = 1'b0; bus.uart_rx = 1'b0;
        repeat (8) step();
        bus.uart_en = 1'b1;
        repeat (48) step();
        chk_flags("break");
        bus.uart_rx = 1'b1;
        repeat (8) step();

        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, "a5");
        clear_flags();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, "3c_p");
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, "c3_p");
        clear_flags();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "55_ferr");
        clear_flags();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, "11");
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, "22_ovr");
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, "33_clr");
        clear_flags();

        // Disable during data bit 3, then a clean frame
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4, "abort");
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, "81");

        // Reset in the middle of a frame discards it
        align();
        step(); bus.uart_rx = 1'b0;
        repeat (40) step();
        sys_rstn = 1'b0;
        step(); bus.uart_rx = 1'b1;
        m_rxbuf = 8'h00; m_r9 = 1'b0; m_pnd = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        chk_flags("rst_mid");
        sys_rstn = 1'b1;
        repeat (48) step();
        chk_flags("post_rst");
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, "5a_n3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
